// File: rtl/ppm_encoder.sv
// N-channel PPM frame generator: a free-running frame counter paces a
// gap/pulse sequence per channel followed by a sync gap and a sync level.
module ppm_encoder #(
   parameter int unsigned FREQ     = 27,
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned VAL_W    = 8,
   parameter int unsigned FRAME_US = 20000,
   parameter int unsigned GAP_US   = 500,
   parameter int unsigned MIN_US   = 500,
   parameter int unsigned SPAN_US  = 1000
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_CH*VAL_W-1:0]   ch_value,
   input  logic                      enable,
   output logic                      transmit,
   output logic                      rf,
   output logic                      frame_start,
   output logic                      overrun
);

   localparam int unsigned FRAME_CYC = FREQ * FRAME_US;
   localparam int unsigned GAP_CYC   = FREQ * GAP_US;
   localparam int unsigned MIN_CYC   = FREQ * MIN_US;
   localparam int unsigned VAL_MAX   = (1 << VAL_W) - 1;
   localparam int unsigned STEP_CYC  = (FREQ * SPAN_US) / VAL_MAX;
   localparam int unsigned ON_MAX    = MIN_CYC + VAL_MAX * STEP_CYC;
   localparam int unsigned SEG_MAX   = (ON_MAX > GAP_CYC) ? ON_MAX : GAP_CYC;
   localparam int unsigned FRAME_W   = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
   localparam int unsigned SEG_W     = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;
   localparam int unsigned ON_W      = $clog2(ON_MAX + 1);
   localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned SH_W      = NUM_CH * VAL_W;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_GAP      = 3'd1,
      S_PULSE    = 3'd2,
      S_SYNC_GAP = 3'd3,
      S_SYNC     = 3'd4
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [FRAME_W-1:0]  r_frame_cnt, w_frame_nxt;
   logic [SEG_W-1:0]    r_seg_cnt, w_seg_nxt;
   logic [CH_W-1:0]     r_ch_idx, w_ch_nxt;
   logic [SH_W-1:0]     r_shadow, w_shadow_nxt;
   logic                r_transmit, w_tx_nxt;
   logic                r_frame_start, w_fs_nxt;
   logic                r_overrun, w_ovr_nxt;

   logic                w_boundary;
   logic                w_seg_zero;
   logic                w_last_ch;
   logic                w_seq_active;
   logic [VAL_W-1:0]    w_val;
   logic [ON_W-1:0]     w_on_cyc;
   logic [SEG_W-1:0]    w_on_load;
   logic [SEG_W-1:0]    w_gap_load;

   assign w_boundary   = (r_frame_cnt == '0);
   assign w_seg_zero   = (r_seg_cnt == '0);
   assign w_last_ch    = (r_ch_idx == CH_W'(NUM_CH - 1));
   assign w_seq_active = (r_state == S_GAP) || (r_state == S_PULSE) ||
                         (r_state == S_SYNC_GAP);
   assign w_gap_load   = SEG_W'(GAP_CYC - 1);

   // Current channel value from the frame-stable shadow copy
   always_comb begin
      w_val = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         if (r_ch_idx == CH_W'(k)) begin
            w_val = r_shadow[k*VAL_W +: VAL_W];
         end
      end
   end

   assign w_on_cyc  = ON_W'(MIN_CYC) + ON_W'(w_val) * ON_W'(STEP_CYC);
   assign w_on_load = SEG_W'(w_on_cyc - ON_W'(1));

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_frame_cnt   <= '0;
         r_seg_cnt     <= '0;
         r_ch_idx      <= '0;
         r_shadow      <= '0;
         r_transmit    <= 1'b0;
         r_frame_start <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_frame_cnt   <= w_frame_nxt;
         r_seg_cnt     <= w_seg_nxt;
         r_ch_idx      <= w_ch_nxt;
         r_shadow      <= w_shadow_nxt;
         r_transmit    <= w_tx_nxt;
         r_frame_start <= w_fs_nxt;
         r_overrun     <= w_ovr_nxt;
      end
   end

   // Next-state: frame boundary overrides any segment transition
   always_comb begin
      w_state_nxt  = r_state;
      w_seg_nxt    = r_seg_cnt;
      w_ch_nxt     = r_ch_idx;
      w_shadow_nxt = r_shadow;
      w_frame_nxt  = w_boundary ? FRAME_W'(FRAME_CYC - 1) : r_frame_cnt - FRAME_W'(1);

      if (w_boundary) begin
         if (enable) begin
            w_shadow_nxt = ch_value;
            w_ch_nxt     = '0;
            w_seg_nxt    = w_gap_load;
            w_state_nxt  = S_GAP;
         end else begin
            w_state_nxt  = S_IDLE;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_IDLE;
            end
            S_GAP: begin
               if (!w_seg_zero) begin
                  w_seg_nxt = r_seg_cnt - SEG_W'(1);
               end else begin
                  w_seg_nxt   = w_on_load;
                  w_state_nxt = S_PULSE;
               end
            end
            S_PULSE: begin
               if (!w_seg_zero) begin
                  w_seg_nxt = r_seg_cnt - SEG_W'(1);
               end else begin
                  w_seg_nxt = w_gap_load;
                  if (w_last_ch) begin
                     w_state_nxt = S_SYNC_GAP;
                  end else begin
                     w_ch_nxt    = r_ch_idx + CH_W'(1);
                     w_state_nxt = S_GAP;
                  end
               end
            end
            S_SYNC_GAP: begin
               if (!w_seg_zero) begin
                  w_seg_nxt = r_seg_cnt - SEG_W'(1);
               end else begin
                  w_state_nxt = S_SYNC;
               end
            end
            S_SYNC: begin
               w_state_nxt = S_SYNC;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Output next values; carrier envelope changes on the edge that ends a segment
   always_comb begin
      w_tx_nxt  = r_transmit;
      w_fs_nxt  = w_boundary;
      w_ovr_nxt = r_overrun | (w_boundary & w_seq_active);

      if (w_boundary) begin
         w_tx_nxt = 1'b0;
      end else begin
         case (r_state)
            S_IDLE:     w_tx_nxt = 1'b0;
            S_GAP:      if (w_seg_zero) w_tx_nxt = 1'b1;
            S_PULSE:    if (w_seg_zero) w_tx_nxt = 1'b0;
            S_SYNC_GAP: if (w_seg_zero) w_tx_nxt = 1'b1;
            S_SYNC:     w_tx_nxt = 1'b1;
            default:    w_tx_nxt = 1'b0;
         endcase
      end
   end

   assign transmit    = r_transmit;
   assign frame_start = r_frame_start;
   assign overrun     = r_overrun;
   assign rf          = r_transmit & clock;

endmodule

// File: tb/tb_ppm_encoder.sv
// Bench for ppm_encoder: a frame-position model predicts every output cycle,
// plus literal waypoints for the directed scenarios and randomized traffic.
module tb_ppm_encoder;

   localparam int unsigned FREQ    = 1;
   localparam int unsigned NCH     = 3;
   localparam int unsigned VW      = 4;
   localparam int unsigned GAP_US  = 5;
   localparam int unsigned MIN_US  = 5;
   localparam int unsigned SPAN_US = 15;
   localparam int unsigned GAP     = FREQ * GAP_US;
   localparam int unsigned MINC    = FREQ * MIN_US;
   localparam int unsigned STEP    = (FREQ * SPAN_US) / ((1 << VW) - 1);
   localparam int unsigned CW      = NCH * VW;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b0;
   logic [CW-1:0] ch_value  = '0;
   logic [CW-1:0] ch_value2 = '0;
   logic          enable  = 1'b0;
   logic          enable2 = 1'b0;
   logic          tx1, rf1, fs1, ov1;
   logic          tx2, rf2, fs2, ov2;

   int errors = 0;
   int checks = 0;
   int cyc    = -1;

   // Model state per instance: position in frame, frame active, latched values
   int            flen [2] = '{200, 40};
   int            pos  [2] = '{199, 39};
   logic          act  [2] = '{1'b0, 1'b0};
   logic          ovr_m[2] = '{1'b0, 1'b0};
   logic          fs_m [2] = '{1'b0, 1'b0};
   logic [CW-1:0] sh   [2] = '{'0, '0};

   ppm_encoder #(.FREQ(FREQ), .NUM_CH(NCH), .VAL_W(VW), .FRAME_US(200),
                 .GAP_US(GAP_US), .MIN_US(MIN_US), .SPAN_US(SPAN_US)) dut (
      .clock(clock), .reset_n(reset_n), .ch_value(ch_value), .enable(enable),
      .transmit(tx1), .rf(rf1), .frame_start(fs1), .overrun(ov1));

   ppm_encoder #(.FREQ(FREQ), .NUM_CH(NCH), .VAL_W(VW), .FRAME_US(40),
                 .GAP_US(GAP_US), .MIN_US(MIN_US), .SPAN_US(SPAN_US)) dut_short (
      .clock(clock), .reset_n(reset_n), .ch_value(ch_value2), .enable(enable2),
      .transmit(tx2), .rf(rf2), .frame_start(fs2), .overrun(ov2));

   always #5 clock = ~clock;

   function automatic int on_cyc(input logic [VW-1:0] v);
      return int'(MINC) + int'(v) * int'(STEP);
   endfunction

   function automatic int seq_len(input logic [CW-1:0] cv);
      int s = int'(GAP);
      for (int k = 0; k < int'(NCH); k++) s += int'(GAP) + on_cyc(cv[k*VW +: VW]);
      return s;
   endfunction

   // Carrier envelope at position p of a frame carrying values cv
   function automatic logic wave(input int p, input logic [CW-1:0] cv);
      int t = p;
      for (int k = 0; k < int'(NCH); k++) begin
         if (t < int'(GAP)) return 1'b0;
         t -= int'(GAP);
         if (t < on_cyc(cv[k*VW +: VW])) return 1'b1;
         t -= on_cyc(cv[k*VW +: VW]);
      end
      if (t < int'(GAP)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic exp_tx(input int i);
      return act[i] ? wave(pos[i], sh[i]) : 1'b0;
   endfunction

   task automatic chk(input string name, input logic actual, input logic req);
      checks++;
      if (actual !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, actual, req);
      end
   endtask

   task automatic at(input int n);
      int guard = 0;
      while (cyc < n && guard < 10000) begin
         @(negedge clock);
         guard++;
      end
      if (cyc != n) begin
         checks++;
         errors++;
         $display("FAIL at_cyc actual=%0d required=%0d", cyc, n);
      end
   endtask

   // Reference model advanced on each clock edge
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cyc = -1;
         for (int i = 0; i < 2; i++) begin
            pos[i] = flen[i] - 1; act[i] = 1'b0; ovr_m[i] = 1'b0; fs_m[i] = 1'b0;
         end
      end else begin
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (pos[i] == flen[i] - 1) begin
               if (act[i] && (flen[i] - 1 < seq_len(sh[i]))) ovr_m[i] = 1'b1;
               act[i] = (i == 0) ? enable : enable2;
               if (act[i]) sh[i] = (i == 0) ? ch_value : ch_value2;
               pos[i]  = 0;
               fs_m[i] = 1'b1;
            end else begin
               pos[i]++;
               fs_m[i] = 1'b0;
            end
         end
      end
   end

   // Per-cycle comparison against the model
   always begin
      @(posedge clock);
      #1;
      if (reset_n) begin
         chk("rf_high0", rf1, exp_tx(0));
         chk("rf_high1", rf2, exp_tx(1));
      end
      @(negedge clock);
      if (reset_n) begin
         chk("tx0", tx1, exp_tx(0));
         chk("fs0", fs1, fs_m[0]);
         chk("ov0", ov1, ovr_m[0]);
         chk("rf_low0", rf1, 1'b0);
         chk("tx1", tx2, exp_tx(1));
         chk("fs1", fs2, fs_m[1]);
         chk("ov1", ov2, ovr_m[1]);
      end
   end

   // Hand-computed waypoints for values {0,7,15} and the all-15 short frame
   task automatic s1_checks();
      at(0);   chk("s1_fs_c0", fs1, 1'b1); chk("s1_tx_c0", tx1, 1'b0);
      at(1);   chk("s1_fs_c1", fs1, 1'b0);
      at(4);   chk("s1_tx_c4", tx1, 1'b0);
      at(5);   chk("s1_tx_c5", tx1, 1'b1);
      at(10);  chk("s1_tx_c10", tx1, 1'b0);
      at(15);  chk("s1_tx_c15", tx1, 1'b1);
      at(27);  chk("s1_tx_c27", tx1, 1'b0);
      at(32);  chk("s1_tx_c32", tx1, 1'b1);
      at(39);  chk("s4_ov_c39", ov2, 1'b0);
      at(40);  chk("s4_ov_c40", ov2, 1'b1); chk("s4_fs_c40", fs2, 1'b1);
      at(45);  chk("s4_tx_c45", tx2, 1'b1);
      at(51);  chk("s1_tx_c51", tx1, 1'b1);
      at(52);  chk("s1_tx_c52", tx1, 1'b0);
      at(57);  chk("s1_tx_c57", tx1, 1'b1);
      at(79);  chk("s4_tx_c79", tx2, 1'b1);
      at(199); chk("s1_tx_c199", tx1, 1'b1); chk("s1_fs_c199", fs1, 1'b0);
               chk("s1_ov_c199", ov1, 1'b0);
      at(200); chk("s1_fs_c200", fs1, 1'b1); chk("s1_tx_c200", tx1, 1'b0);
   endtask

   initial begin
      enable    = 1'b1;
      enable2   = 1'b1;
      ch_value  = {4'd15, 4'd7, 4'd0};
      ch_value2 = {4'd15, 4'd15, 4'd15};
      reset_n   = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_tx", tx1, 1'b0); chk("rst_fs", fs1, 1'b0); chk("rst_ov", ov1, 1'b0);
      reset_n = 1'b1;
      s1_checks();

      // Mid-frame value change only takes effect at the next boundary
      at(220); ch_value = {4'd15, 4'd15, 4'd15};
      at(227); chk("s2_tx_c227", tx1, 1'b0);
      at(252); chk("s2_tx_c252", tx1, 1'b0);
      at(400); chk("s2_fs_c400", fs1, 1'b1);
      at(424); chk("s2_tx_c424", tx1, 1'b1);
      at(425); chk("s2_tx_c425", tx1, 1'b0);
      at(475); chk("s2_tx_c475", tx1, 1'b0);
      at(480); chk("s2_tx_c480", tx1, 1'b1);

      // Enable dropped mid-frame: frame completes, then idle until re-enabled
      at(650);  enable = 1'b0;
      at(657);  chk("s3_tx_c657", tx1, 1'b1);
      at(799);  chk("s3_tx_c799", tx1, 1'b1);
      at(800);  chk("s3_fs_c800", fs1, 1'b1); chk("s3_tx_c800", tx1, 1'b0);
      at(880);  chk("s3_tx_c880", tx1, 1'b0);
      at(1000); chk("s3_fs_c1000", fs1, 1'b1);
      at(1050); enable = 1'b1;
      at(1199); chk("s3_tx_c1199", tx1, 1'b0);
      at(1200); chk("s3_fs_c1200", fs1, 1'b1);
      at(1205); chk("s3_tx_c1205", tx1, 1'b1);

      // Asynchronous reset in the middle of a pulse
      at(1235); chk("s5_tx_pre", tx1, 1'b1); chk("s5_ov2_pre", ov2, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("s5_tx_rst", tx1, 1'b0); chk("s5_fs_rst", fs1, 1'b0);
      chk("s5_ov_rst", ov1, 1'b0); chk("s5_ov2_rst", ov2, 1'b0);
      ch_value = {4'd15, 4'd7, 4'd0};
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      s1_checks();

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         @(negedge clock);
         if ($urandom_range(0, 49) == 0)  ch_value  = CW'($urandom);
         if ($urandom_range(0, 99) == 0)  ch_value2 = CW'($urandom);
         if ($urandom_range(0, 299) == 0) enable    = ~enable;
         if ($urandom_range(0, 399) == 0) enable2   = ~enable2;
         if (k == 1500) begin
            #3 reset_n = 1'b0;
            @(negedge clock);
            @(negedge clock);
            reset_n = 1'b1;
         end
      end
      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "timeout");
   end

endmodule
